// File: rtl/clkdiv_pkg.sv
// Shared constants and types for the clk_div_gen tick-enable generator.
package clkdiv_pkg;

    localparam int unsigned CLKDIV_MAX_CH = 16;
    localparam int unsigned CLKDIV_CNT_W  = 16;
    localparam int unsigned CLKDIV_LOCK_W = 16;

    typedef logic [CLKDIV_CNT_W-1:0] div_t;

    // Channel-select width, never narrower than one bit.
    function automatic int unsigned clkdiv_ch_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: down-counter with active/pending divisor, tick pulse and
// optional square wave (built only when CLKDIV_SQ_EN is defined).
module clkdiv_channel
    import clkdiv_pkg::*;
#(
    parameter int unsigned CNT_W       = CLKDIV_CNT_W,
    parameter int unsigned DEFAULT_DIV = 25
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             wr_i,
    input  logic [CNT_W-1:0] wr_div_i,
    output logic             tick_o,
    output logic             sq_o,
    output logic             pend_vld_o,
    output logic             pend_vld_d_o
);

    localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] DEF_CNT = (DEF_DIV == '0) ? '0 : DEF_DIV - CNT_W'(1);

    logic [CNT_W-1:0] active_q, active_d;
    logic [CNT_W-1:0] pend_div_q, pend_div_d;
    logic             pend_vld_q, pend_vld_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;

    // Counter start value for a divisor; a zero divisor parks the counter at 0.
    function automatic logic [CNT_W-1:0] load_val(input logic [CNT_W-1:0] d);
        return (d == '0) ? '0 : d - CNT_W'(1);
    endfunction

    always_comb begin
        active_d   = active_q;
        pend_div_d = pend_div_q;
        pend_vld_d = pend_vld_q;
        cnt_d      = cnt_q;
        tick_d     = 1'b0;
        if (active_q == '0) begin
            cnt_d = '0;
            if (wr_i) begin
                active_d = wr_div_i;
                cnt_d    = load_val(wr_div_i);
            end
        end else if (!en_i) begin
            // A pending value left over when the channel is disabled applies at once.
            if (pend_vld_q) begin
                active_d   = pend_div_q;
                pend_vld_d = 1'b0;
            end
            cnt_d = load_val(active_d);
            if (wr_i) begin
                active_d = wr_div_i;
                cnt_d    = load_val(wr_div_i);
            end
        end else begin
            if (cnt_q == '0) begin
                tick_d     = 1'b1;
                active_d   = pend_vld_q ? pend_div_q : active_q;
                cnt_d      = load_val(active_d);
                pend_vld_d = 1'b0;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
            // Set after the reload so a write on the terminal count waits one period.
            if (wr_i) begin
                pend_div_d = wr_div_i;
                pend_vld_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q   <= DEF_DIV;
            pend_div_q <= '0;
            pend_vld_q <= 1'b0;
            cnt_q      <= DEF_CNT;
            tick_q     <= 1'b0;
        end else begin
            active_q   <= active_d;
            pend_div_q <= pend_div_d;
            pend_vld_q <= pend_vld_d;
            cnt_q      <= cnt_d;
            tick_q     <= tick_d;
        end
    end

    assign tick_o       = tick_q;
    assign pend_vld_o   = pend_vld_q;
    assign pend_vld_d_o = pend_vld_d;

`ifdef CLKDIV_SQ_EN
    logic sq_q, sq_d;

    assign sq_d = sq_q ^ tick_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sq_q <= 1'b0;
        end else begin
            sq_q <= sq_d;
        end
    end

    assign sq_o = sq_q;
`else
    assign sq_o = 1'b0;
`endif

endmodule

// File: rtl/clk_div_gen.sv
// Multi-channel programmable tick-enable generator: config decode, ready mux and
// lock tracking around NUM_CH clkdiv_channel instances. Square waves need CLKDIV_SQ_EN.
module clk_div_gen
    import clkdiv_pkg::*;
#(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned CNT_W       = CLKDIV_CNT_W,
    parameter int unsigned DEFAULT_DIV = 25,
    parameter int unsigned LOCK_CYCLES = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           cfg_valid,
    output logic                           cfg_ready,
    input  logic [clkdiv_ch_w(NUM_CH)-1:0] cfg_ch,
    input  logic [CNT_W-1:0]               cfg_div,
    input  logic [NUM_CH-1:0]              ch_en,
    output logic [NUM_CH-1:0]              tick,
    output logic [NUM_CH-1:0]              sq,
    output logic                           locked
);

    localparam int unsigned CH_W = clkdiv_ch_w(NUM_CH);
    localparam int unsigned SEL_N = 1 << CH_W;
    localparam logic [CLKDIV_LOCK_W-1:0] LOCK_MAX = CLKDIV_LOCK_W'(LOCK_CYCLES);

    logic [NUM_CH-1:0]        pend_vld;
    logic [NUM_CH-1:0]        pend_vld_nxt;
    logic [NUM_CH-1:0]        wr;
    logic [SEL_N-1:0]         pend_ext;
    logic [CLKDIV_LOCK_W-1:0] lock_cnt_q, lock_cnt_d;
    logic                     locked_q, locked_d;

    // Unused select codes read as "no pending", so out-of-range writes are accepted and dropped.
    always_comb begin
        pend_ext             = '0;
        pend_ext[NUM_CH-1:0] = pend_vld;
    end

    assign cfg_ready = !pend_ext[cfg_ch];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign wr[i] = cfg_valid && cfg_ready && (cfg_ch == CH_W'(i));

        clkdiv_channel #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk          (clk),
            .rst_n        (rst_n),
            .en_i         (ch_en[i]),
            .wr_i         (wr[i]),
            .wr_div_i     (cfg_div),
            .tick_o       (tick[i]),
            .sq_o         (sq[i]),
            .pend_vld_o   (pend_vld[i]),
            .pend_vld_d_o (pend_vld_nxt[i])
        );
    end

    // Lock uses next-state pending flags so it tracks accept/apply with one cycle of latency.
    always_comb begin
        lock_cnt_d = lock_cnt_q;
        if (lock_cnt_q != LOCK_MAX) begin
            lock_cnt_d = lock_cnt_q + CLKDIV_LOCK_W'(1);
        end
        locked_d = (lock_cnt_d == LOCK_MAX) && !(|pend_vld_nxt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_cnt_q <= '0;
            locked_q   <= 1'b0;
        end else begin
            lock_cnt_q <= lock_cnt_d;
            locked_q   <= locked_d;
        end
    end

    assign locked = locked_q;

endmodule

// File: tb/tb_clk_div_gen.sv
// Directed self-checking bench for clk_div_gen (default parameters).
module tb_clk_div_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_ch;
    logic [15:0] cfg_div;
    logic [3:0]  ch_en;
    logic [3:0]  tick;
    logic [3:0]  sq;
    logic        locked;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    clk_div_gen dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .ch_en     (ch_en),
        .tick      (tick),
        .sq        (sq),
        .locked    (locked)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cfg_valid = 1'b0; cfg_ch = 2'd0; cfg_div = 16'd0; ch_en = 4'b0000;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (tick !== 4'b0000) begin failures++; $display("FAIL reset_tick got=%b exp=0000", tick); end
        checks++; if (sq !== 4'b0000) begin failures++; $display("FAIL reset_sq got=%b exp=0000", sq); end
        checks++; if (locked !== 1'b0) begin failures++; $display("FAIL reset_locked got=%b exp=0", locked); end
        checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", cfg_ready); end
        rst_n = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            step();
            checks++;
            if (locked !== (k >= 16)) begin
                failures++; $display("FAIL lock_delay k=%0d got=%b exp=%b", k, locked, k >= 16);
            end
        end
    endtask

    task automatic test_default_div();
        ch_en[0] = 1'b1;
        for (int k = 1; k <= 50; k++) begin
            step();
            checks++;
            if (tick[0] !== (k == 25 || k == 50)) begin
                failures++; $display("FAIL ch0_default_tick k=%0d got=%b exp=%b", k, tick[0], (k == 25 || k == 50));
            end
        end
    endtask

    task automatic test_pending();
        ch_en[1] = 1'b1;
        repeat (10) step();
        cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 16'd4;
        #1;
        checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL pend_first_ready got=%b exp=1", cfg_ready); end
        step();
        cfg_div = 16'd7;
        #1;
        checks++; if (cfg_ready !== 1'b0) begin failures++; $display("FAIL pend_second_ready got=%b exp=0", cfg_ready); end
        checks++; if (locked !== 1'b0) begin failures++; $display("FAIL pend_lock_drop got=%b exp=0", locked); end
        for (int k = 12; k <= 25; k++) begin
            step();
            checks++;
            if (tick[1] !== (k == 25)) begin failures++; $display("FAIL pend_old_period k=%0d got=%b exp=%b", k, tick[1], k == 25); end
            checks++;
            if (locked !== (k == 25)) begin failures++; $display("FAIL pend_locked k=%0d got=%b exp=%b", k, locked, k == 25); end
            checks++;
            if (cfg_ready !== (k == 25)) begin failures++; $display("FAIL pend_ready k=%0d got=%b exp=%b", k, cfg_ready, k == 25); end
        end
        step();
        cfg_valid = 1'b0;
        checks++; if (locked !== 1'b0) begin failures++; $display("FAIL pend_second_lock got=%b exp=0", locked); end
        for (int k = 27; k <= 43; k++) begin
            step();
            checks++;
            if (tick[1] !== (k == 29 || k == 36 || k == 43)) begin
                failures++; $display("FAIL pend_new_period k=%0d got=%b exp=%b", k, tick[1], (k == 29 || k == 36 || k == 43));
            end
            checks++;
            if (locked !== (k >= 29)) begin failures++; $display("FAIL pend_relock k=%0d got=%b exp=%b", k, locked, k >= 29); end
        end
    endtask

    task automatic test_stall();
        cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_div = 16'd0;
        #1;
        checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL stall_ready got=%b exp=1", cfg_ready); end
        step();
        cfg_valid = 1'b0;
        checks++; if (locked !== 1'b1) begin failures++; $display("FAIL stall_direct_lock got=%b exp=1", locked); end
        ch_en[2] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            checks++;
            if (tick[2] !== 1'b0) begin failures++; $display("FAIL stall_no_tick k=%0d got=%b exp=0", k, tick[2]); end
        end
        cfg_valid = 1'b1; cfg_div = 16'd1;
        step();
        cfg_valid = 1'b0;
        checks++; if (tick[2] !== 1'b0) begin failures++; $display("FAIL div1_accept_tick got=%b exp=0", tick[2]); end
        for (int k = 1; k <= 8; k++) begin
            step();
            checks++;
            if (tick[2] !== 1'b1) begin failures++; $display("FAIL div1_tick k=%0d got=%b exp=1", k, tick[2]); end
            checks++;
            if (locked !== 1'b1) begin failures++; $display("FAIL div1_locked k=%0d got=%b exp=1", k, locked); end
        end
    endtask

    task automatic test_terminal_write();
        cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_div = 16'd3;
        step();
        cfg_valid = 1'b0;
        ch_en[3] = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            if (k == 6) begin
                cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_div = 16'd5;
            end
            step();
            cfg_valid = 1'b0;
            checks++;
            if (tick[3] !== (k == 3 || k == 6 || k == 9 || k == 14 || k == 19)) begin
                failures++; $display("FAIL tc_tick k=%0d got=%b exp=%b", k, tick[3], (k == 3 || k == 6 || k == 9 || k == 14 || k == 19));
            end
            checks++;
            if (locked !== !(k >= 6 && k < 9)) begin
                failures++; $display("FAIL tc_locked k=%0d got=%b exp=%b", k, locked, !(k >= 6 && k < 9));
            end
        end
    endtask

    task automatic test_reset_mid_pending();
        cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 16'd9;
        step();
        cfg_valid = 1'b0;
        #1;
        checks++; if (cfg_ready !== 1'b0) begin failures++; $display("FAIL rstmid_pending_ready got=%b exp=0", cfg_ready); end
        checks++; if (locked !== 1'b0) begin failures++; $display("FAIL rstmid_pending_lock got=%b exp=0", locked); end
        rst_n = 1'b0;
        #1;
        checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL rstmid_ready got=%b exp=1", cfg_ready); end
        checks++; if (tick !== 4'b0000) begin failures++; $display("FAIL rstmid_tick got=%b exp=0000", tick); end
        checks++; if (locked !== 1'b0) begin failures++; $display("FAIL rstmid_locked got=%b exp=0", locked); end
        ch_en = 4'b0010;
        step();
        step();
        rst_n = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            step();
            checks++;
            if (tick !== ((k == 25) ? 4'b0010 : 4'b0000)) begin
                failures++; $display("FAIL rstmid_div25 k=%0d got=%b exp=%b", k, tick, (k == 25) ? 4'b0010 : 4'b0000);
            end
            checks++;
            if (locked !== (k >= 16)) begin failures++; $display("FAIL rstmid_relock k=%0d got=%b exp=%b", k, locked, k >= 16); end
        end
    endtask

    task automatic test_square();
        logic exp_sq;
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 16'd3;
        step();
        cfg_valid = 1'b0;
        checks++; if (sq[0] !== 1'b0) begin failures++; $display("FAIL sq_start got=%b exp=0", sq[0]); end
        ch_en[0] = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            step();
            checks++;
            if (tick[0] !== (k % 3 == 0)) begin failures++; $display("FAIL sq_tick k=%0d got=%b exp=%b", k, tick[0], k % 3 == 0); end
`ifdef CLKDIV_SQ_EN
            exp_sq = (((k - 1) / 3) % 2) == 1;
            checks++;
            if (sq[0] !== exp_sq) begin failures++; $display("FAIL sq_wave k=%0d got=%b exp=%b", k, sq[0], exp_sq); end
`else
            exp_sq = 1'b0;
            checks++;
            if (sq !== 4'b0000) begin failures++; $display("FAIL sq_tied k=%0d got=%b exp=0000", k, sq); end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_default_div();
        test_pending();
        test_stall();
        test_terminal_write();
        test_reset_mid_pending();
        test_square();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/clk_div_gen.md
# clk_div_gen

Multi-channel programmable clock-enable generator: the parametrised successor to the fixed divide-by-4 clock divider at the top of the synthesizer. It runs entirely on the single divided system clock and produces, per channel, a one-cycle `tick` enable at `clk / div` with a runtime-programmable divisor. Divisor changes are glitch-free, applied only at a period boundary. Sample-rate, envelope and note-pitch logic consume these ticks instead of deriving new clocks.

## Interface
Parameters:
- `NUM_CH`, 4: number of independent channels (1..16).
- `CNT_W`, 16: divisor/counter width.
- `DEFAULT_DIV`, 25: divisor loaded into every channel at reset; must be < 2^CNT_W.
- `LOCK_CYCLES`, 16: cycles after reset release before `locked` may assert.

Ports:
- `clk`  in  1  system clock; all flops on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cfg_valid`  in  1  divisor write request.
- `cfg_ready`  out  1  write accepted this cycle when high together with `cfg_valid`.
- `cfg_ch`  in  $clog2(NUM_CH) (min 1)  target channel.
- `cfg_div`  in  CNT_W  new divisor.
- `ch_en`  in  NUM_CH  per-channel run enable, level-sensitive.
- `tick`  out  NUM_CH  registered one-cycle enable pulse per channel.
- `sq`  out  NUM_CH  registered square wave per channel (see Configuration).
- `locked`  out  1  all divisors settled, no pending updates.

## Operation
- Per channel: `active_div`, `pend_div`, `pend_vld`, down-counter `cnt`.
- Reset: `active_div`=DEFAULT_DIV, `pend_vld`=0, `cnt`=DEFAULT_DIV-1, `tick`=0, `sq`=0, `locked`=0, lock counter=0. Reset mid-operation drops all pending writes.
- `ch_en`=0: `cnt` held at `active_div`-1, `tick`=0, `sq` holds.
- `ch_en`=1, `active_div`≥1: `cnt` decrements each cycle. At `cnt`==0, `tick` goes to 1 in the following cycle and `cnt` reloads to (`pend_vld` ? `pend_div` : `active_div`)-1. On that reload `active_div` takes `pend_div` and `pend_vld` clears.
- `active_div`==0: channel stalled, no ticks, `cnt`=0. A pending write applies immediately.
- `active_div`==1: `tick` is high every cycle while enabled.
- Config handshake: `cfg_ready` = !`pend_vld[cfg_ch]`, combinational. On accept:
  - Channel disabled or stalled: `active_div` and `cnt` load directly; no pending.
  - Channel running: `pend_div`/`pend_vld` set.
  - Write in the same cycle the channel is at `cnt`==0: reload uses the old value; the new value applies at the next terminal count.
- `cfg_ch` ≥ NUM_CH: accepted (`cfg_ready`=1) and discarded.
- `locked`: the lock counter saturates at LOCK_CYCLES after reset release. `locked` = counter saturated AND no channel `pend_vld`. It drops the cycle after any pending write is accepted and rises the cycle after the last pending write is applied.

## Timing
- Enable-to-first-tick: `ch_en` rising sampled at edge 0 → `tick` high in the cycle after edge `active_div`.
- Steady-state tick period is exactly `active_div` cycles with no jitter.
- Config-to-effect:
  - Disabled channel: next cycle.
  - Running channel: at most `active_div` cycles plus one full old period if the write coincides with the terminal count.
- `cfg_ready` has zero-cycle dependence on `cfg_ch`. No other combinational input-to-output paths.

## Configuration
- `CLKDIV_SQ_EN` defined:
  - `sq[i]` toggles on every cycle in which `tick[i]` is asserted, giving a period of 2·`active_div`, 50% duty.
  - This is the raw tone source for the oscillator bank.
- `CLKDIV_SQ_EN` undefined: no `sq` flops are built and `sq` is tied to 0. The port list is unchanged.

## Structure
- Package `clkdiv_pkg`:
  - `CLKDIV_MAX_CH` = 16.
  - Typedef `div_t` (logic [CNT_W-1:0] default 16).
  - Lock-counter width constant.
- Sub-module `clkdiv_channel`: one counter with active/pending registers, `tick` and `sq`. It is instantiated NUM_CH times via generate.
- The top level holds the config decode, `cfg_ready` mux and lock logic.

## Test plan
- Reset, ch0 enabled, default div 25 → first `tick[0]` 25 cycles after enable, then every 25 cycles; `locked` high 16 cycles after `rst_n` release.
- Write div=4 to running ch1 mid-period (old div 25) → current 25-cycle period completes, then ticks every 4; `locked` low from accept until applied.
- Second write to ch1 while pending → `cfg_ready`=0 until the first write applies, then accepted.
- Write div=0 to disabled ch2, then enable → no ticks; write div=1 → `tick[2]` high every cycle from the next cycle.
- Write coinciding with ch3 `cnt`==0 → one extra old period observed before the new divisor.
- With `CLKDIV_SQ_EN` and div=3: `sq[0]` period 6, high 3 / low 3. Without the macro: `sq`=0 always. Assert `rst_n` mid-pending → pending lost, divisor returns to 25.
